mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, fixed-latency memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the pipelined processor. The arbiter accepts one access at a time and drives the memory. It returns read data or a write acknowledge to the requester that owns the access. It gives the data port priority, with a starvation guard for fetch. IF/MEM stage logic uses the grant/valid handshakes to build `disable_PC`/`disable_IR`/stall conditions.

## Interface
- `MEM_LAT`, 2: memory read latency in cycles (legal 1..7).
- `STARVE_MAX`, 4: number of consecutive lost contentions after which fetch wins once (legal 1..15).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_async_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out 32: fetch data.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = write.
- `d_addr` in 32: data address.
- `d_wdata` in 32: write data.
- `d_gnt` out 1: data accepted this cycle.
- `d_rvalid` out 1: read data valid, or write complete.
- `d_rdata` out 32: read data (0 for writes).
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid `MEM_LAT` cycles after `mem_en`.
- `busy` out 1: access outstanding.

## Operation
- FSM states: IDLE and ACCESS. Registers: `owner` (0 = fetch, 1 = data), `lat_cnt` (3 bits), `starve_cnt` (4 bits).
- IDLE with no request:
  - all `gnt`/`mem_*` outputs are 0.
- IDLE with a request:
  - Select a winner: data wins if `d_req`, unless `if_req` is set and `starve_cnt == STARVE_MAX`; fetch wins if only `if_req` is set.
  - The winner's `gnt` is 1 (Mealy, combinational from `req`).
  - `mem_en` = 1, and `mem_addr`/`mem_we`/`mem_wdata` come from the winner. Fetch drives `mem_we` = 0 and `mem_wdata` = 0.
  - At the edge: state moves to ACCESS, `owner` is set to the winner, `lat_cnt` is set to `MEM_LAT-1`.
- `starve_cnt`:
  - Increments (saturating at `STARVE_MAX`) on a grant to data while `if_req` = 1.
  - Clears on any fetch grant.
  - Otherwise holds.
- ACCESS:
  - `busy` = 1. `mem_en` = 0 and both grants are 0.
  - `lat_cnt` decrements each cycle while nonzero.
  - When `lat_cnt` = 0: the owner's `rvalid` = 1 for exactly one cycle, and `rdata` = `mem_rdata` (reads) or 0 (writes). The next edge returns the FSM to IDLE.
- Non-owner outputs: `rvalid` = 0 and `rdata` = 0 at all times.
- Requester contract:
  - Hold `req`, address, and data stable until `gnt`.
  - A requester may re-request only after its `rvalid`.
  - A request made during ACCESS waits; it is never lost and never granted early.
- No overlap: the earliest next grant is the cycle after `rvalid`.
- Reset mid-access: FSM goes to IDLE and all counters to 0. The outstanding access is dropped with no `rvalid`, and the memory result is ignored.

## Timing
- Reset values: every output is 0, `busy` = 0, state IDLE, `lat_cnt` = 0, `starve_cnt` = 0.
- A grant in cycle T produces:
  - `mem_en` in T;
  - `busy` in T+1 through T+`MEM_LAT`;
  - `rvalid` in T+`MEM_LAT`.
- Throughput: one access per `MEM_LAT`+1 cycles under continuous requests.
- Combinational paths: `req` → `gnt`/`mem_*` within a cycle, and `mem_rdata` → `rdata` within the `rvalid` cycle. All state is registered.
- Reset asserts asynchronously, forcing outputs to 0 immediately. Deassertion takes effect at the next `clk` edge.

## Test plan
- Single fetch: `if_req`, `if_addr` = 0x100, memory returns 0xDEADBEEF, `MEM_LAT` = 2. Required: `if_gnt` and `mem_en` in T; `busy` in T+1..T+2; `if_rvalid` with `if_rdata` = 0xDEADBEEF in T+2; `d_rvalid` = 0 throughout.
- Contention: `if_req` and `d_req` both set in T with `starve_cnt` = 0. Required: `d_gnt` in T; `d_rvalid` in T+2; `if_gnt` in T+3.
- Starvation: `d_req` held high and re-issued after each `d_rvalid`, `if_req` held high, `STARVE_MAX` = 4. Required: four data grants (T, T+3, T+6, T+9), then `if_gnt` at T+12, after which `starve_cnt` reads 0.
- Write: `d_we` = 1, `d_addr` = 0x40, `d_wdata` = 0x12345678. Required: `mem_we` = 1 with the same address and data in T; `d_rvalid` in T+2 with `d_rdata` = 0.
- Reset mid-access: grant in T, `rst_async_n` low during T+1. Required: all outputs 0 immediately; no `rvalid`. After release, a new `if_req` is granted in the first cycle after the releasing edge.
- `MEM_LAT` = 1 with back-to-back fetches: grants in T, T+2, T+4; `if_rvalid` in T+1, T+3, T+5.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch port and the data port.
// Data has priority; fetch wins once after STARVE_MAX consecutive lost contentions.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_async_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] LatInit   = 3'(MEM_LAT - 1);
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e     state_q;
  logic       owner_q;       // 0 = fetch, 1 = data
  logic       we_q;
  logic [2:0] lat_cnt_q;
  logic [3:0] starve_cnt_q;
  // Set at the first edge after reset release so no grant appears before that edge.
  logic       active_q;

  logic idle;
  logic starve_hit;
  logic grant_d;
  logic grant_if;
  logic done;

  assign idle       = (state_q == StIdle) && active_q;
  assign starve_hit = if_req && (starve_cnt_q == StarveMax);
  assign grant_d    = idle && d_req && !starve_hit;
  assign grant_if   = idle && if_req && !grant_d;
  assign done       = (state_q == StAccess) && (lat_cnt_q == 3'd0);

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign mem_en    = grant_if || grant_d;
  assign mem_we    = grant_d && d_we;
  assign mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : 32'd0);
  assign mem_wdata = grant_d ? d_wdata : 32'd0;

  assign busy      = (state_q == StAccess);
  assign if_rvalid = done && !owner_q;
  assign d_rvalid  = done && owner_q;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : 32'd0;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 4'd0;
      active_q     <= 1'b0;
    end else begin
      active_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (grant_d || grant_if) begin
            state_q   <= StAccess;
            owner_q   <= grant_d;
            we_q      <= grant_d && d_we;
            lat_cnt_q <= LatInit;
          end
        end
        StAccess: begin
          if (lat_cnt_q != 3'd0) begin
            lat_cnt_q <= lat_cnt_q - 3'd1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (grant_if) begin
        starve_cnt_q <= 4'd0;
      end else if (grant_d && if_req && (starve_cnt_q != StarveMax)) begin
        starve_cnt_q <= starve_cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter, plus directed reset and MEM_LAT=1 checks.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_async_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Second instance with MEM_LAT = 1.
  logic        if1_req;
  logic [31:0] if1_addr;
  logic        if1_gnt, if1_rvalid, d1_gnt, d1_rvalid;
  logic [31:0] if1_rdata, d1_rdata;
  logic        mem1_en, mem1_we, busy1;
  logic [31:0] mem1_addr, mem1_wdata, mem1_rdata;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_async_n(rst_async_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .rst_async_n(rst_async_n),
    .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt), .if_rvalid(if1_rvalid),
    .if_rdata(if1_rdata), .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
    .d_gnt(d1_gnt), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata), .mem_en(mem1_en),
    .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata),
    .busy(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {25'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}, 32'd0);
    chk(name, if_rdata | d_rdata | mem_addr | mem_wdata, 32'd0);
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 16));
    return a << 4;
  endfunction

  // Reference model memory (from stimulus) and device memory (from DUT mem_* pins).
  logic [31:0] mm      [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : init_val(a);
  endfunction

  function automatic logic [31:0] rdd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  // Stimulus muxing: random drivers when drv_en, directed values otherwise.
  bit          drv_en = 0, chk_en = 0;
  int          pct = 0;
  logic        drv_if_req = 0, drv_d_req = 0, drv_d_we = 0;
  logic [31:0] drv_if_addr = 0, drv_d_addr = 0, drv_d_wdata = 0;
  logic        dir_if_req = 0;
  logic [31:0] dir_if_addr = 0;
  bit          if_wait = 0, d_wait = 0;

  assign if_req  = drv_en ? drv_if_req  : dir_if_req;
  assign if_addr = drv_en ? drv_if_addr : dir_if_addr;
  assign d_req   = drv_en ? drv_d_req   : 1'b0;
  assign d_we    = drv_en ? drv_d_we    : 1'b0;
  assign d_addr  = drv_en ? drv_d_addr  : 32'd0;
  assign d_wdata = drv_en ? drv_d_wdata : 32'd0;

  // Negedge samples of DUT pins used by drivers and memory devices.
  logic        s_if_gnt, s_if_rv, s_d_gnt, s_d_rv, s_en, s_we, s1_en;
  logic [31:0] s_addr, s_wdata, s1_addr;
  initial forever begin
    @(negedge clk);
    s_if_gnt = if_gnt; s_if_rv = if_rvalid; s_d_gnt = d_gnt; s_d_rv = d_rvalid;
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    s1_en = mem1_en; s1_addr = mem1_addr;
  end

  // Memory devices: read data valid exactly MEM_LAT cycles after mem_en, garbage otherwise.
  int          dev_left = 0;
  logic [31:0] dev_data = 0;
  initial begin
    dev_mem[32'h100] = 32'hDEAD_BEEF;
    mem_rdata  = 32'hBAD0_0000;
    mem1_rdata = 32'hBAD1_0000;
    forever begin
      @(posedge clk); #1;
      if (s_en && s_we) dev_mem[s_addr] = s_wdata;
      if (s_en && !s_we) begin
        dev_left = LAT;
        dev_data = rdd(s_addr);
      end else if (dev_left > 0) begin
        dev_left--;
      end
      mem_rdata  = (dev_left == 1) ? dev_data : (32'hBAD0_0000 | 32'(dev_left));
      mem1_rdata = s1_en ? init_val(s1_addr) : 32'hBAD1_0000;
    end
  end

  initial forever begin : if_driver
    @(posedge clk); #1;
    if (drv_en) begin
      if (drv_if_req && s_if_gnt) begin drv_if_req = 0; if_wait = 1; end
      else if (if_wait && s_if_rv) if_wait = 0;
      if (!drv_if_req && !if_wait && ($urandom_range(0, 99) < pct)) begin
        drv_if_req  = 1;
        drv_if_addr = rand_addr();
      end
    end
  end

  initial forever begin : d_driver
    @(posedge clk); #1;
    if (drv_en) begin
      if (drv_d_req && s_d_gnt) begin drv_d_req = 0; d_wait = 1; end
      else if (d_wait && s_d_rv) d_wait = 0;
      if (!drv_d_req && !d_wait && ($urandom_range(0, 99) < pct)) begin
        drv_d_req   = 1;
        drv_d_we    = 1'($urandom_range(0, 1));
        drv_d_addr  = rand_addr();
        drv_d_wdata = $urandom();
      end
    end
  end

  typedef struct {
    bit          owner;  // 1 = data
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Reference model: one access at a time, next grant no earlier than free_at.
  int free_at = 0, starve_m = 0;
  initial begin
    mm[32'h100] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        free_at  = cyc + 1;
        starve_m = 0;
      end else begin
        bit eg_if, eg_d;
        eg_if = 0; eg_d = 0;
        if (cyc >= free_at) begin
          if (d_req && !(if_req && starve_m == SMAX)) eg_d = 1;
          else if (if_req) eg_if = 1;
        end
        chk1("if_gnt", if_gnt, eg_if);
        chk1("d_gnt", d_gnt, eg_d);
        chk1("mem_en", mem_en, eg_if | eg_d);
        chk1("busy", busy, cyc < free_at);
        if (eg_d) begin
          chk1("d_mem_we", mem_we, d_we);
          chk("d_mem_addr", mem_addr, d_addr);
          chk("d_mem_wdata", mem_wdata, d_wdata);
          sb.push_back('{owner: 1'b1, data: d_we ? 32'd0 : rdm(d_addr), due: cyc + LAT});
          if (d_we) mm[d_addr] = d_wdata;
          if (if_req && starve_m < SMAX) starve_m++;
          free_at = cyc + LAT + 1;
        end else if (eg_if) begin
          chk1("if_mem_we", mem_we, 1'b0);
          chk("if_mem_addr", mem_addr, if_addr);
          chk("if_mem_wdata", mem_wdata, 32'd0);
          sb.push_back('{owner: 1'b0, data: rdm(if_addr), due: cyc + LAT});
          starve_m = 0;
          free_at  = cyc + LAT + 1;
        end
      end
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (if_rvalid || d_rvalid) begin
        if (sb.size() == 0) begin
          chk1("spurious_rvalid", if_rvalid | d_rvalid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rvalid_cycle", cyc, e.due);
          chk1("d_rvalid_owner", d_rvalid, e.owner);
          chk1("if_rvalid_owner", if_rvalid, !e.owner);
          chk("rdata", e.owner ? d_rdata : if_rdata, e.data);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        chk1("missing_rvalid", 1'b0, 1'b1);
        void'(sb.pop_front());
      end
      if (!if_rvalid) chk("if_rdata_idle", if_rdata, 32'd0);
      if (!d_rvalid)  chk("d_rdata_idle", d_rdata, 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_async_n = 0;
    if1_req     = 0;
    if1_addr    = 0;
    #3;
    chk_all_zero("reset_outputs");
    dir_if_req  = 1;
    dir_if_addr = 32'h100;
    #1;
    chk_all_zero("reset_gated_req");
    dir_if_req = 0;
    @(negedge clk); @(negedge clk);
    rst_async_n = 1;
    @(posedge clk); #1;
    chk_en = 1;
    drv_en = 1;

    pct = 100;
    repeat (60) @(posedge clk);
    pct = 40;
    repeat (400) @(posedge clk);
    pct = 0;
    k = 0;
    while ((sb.size() != 0 || drv_if_req || drv_d_req || if_wait || d_wait) && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk1("drain_done", k < 200, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 0;
    drv_en = 0;

    // Reset in the middle of an access.
    @(posedge clk); #1;
    dir_if_req  = 1;
    dir_if_addr = 32'h80;
    @(negedge clk);
    chk1("rst_pre_gnt", if_gnt, 1'b1);
    @(posedge clk); #1;
    dir_if_req  = 0;
    rst_async_n = 0;
    #1;
    chk_all_zero("rst_mid_zero");
    dir_if_req  = 1;
    dir_if_addr = 32'h84;
    #1;
    chk_all_zero("rst_mid_gated");
    @(negedge clk);
    chk_all_zero("rst_hold_1");
    @(negedge clk);
    chk_all_zero("rst_hold_2");
    rst_async_n = 1;
    #1;
    chk1("gnt_before_edge", if_gnt, 1'b0);
    @(negedge clk);
    chk1("gnt_after_release", if_gnt, 1'b1);
    chk("release_addr", mem_addr, 32'h84);
    @(posedge clk); #1;
    dir_if_req = 0;
    @(negedge clk);
    chk1("release_busy", busy, 1'b1);
    chk1("release_no_early_rv", if_rvalid, 1'b0);
    @(negedge clk);
    chk1("release_rvalid", if_rvalid, 1'b1);
    chk("release_rdata", if_rdata, rdm(32'h84));
    chk1("release_d_rvalid", d_rvalid, 1'b0);

    // MEM_LAT = 1, fetch held continuously: grant every other cycle.
    @(posedge clk); #1;
    if1_req  = 1;
    if1_addr = 32'h24;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk1("lat1_gnt", if1_gnt, (j % 2) == 0);
      chk1("lat1_rvalid", if1_rvalid, (j % 2) == 1);
      chk("lat1_rdata", if1_rdata, ((j % 2) == 1) ? init_val(32'h24) : 32'd0);
    end
    @(posedge clk); #1;
    if1_req = 0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
